// File: rtl/deser_pkg.sv
// Shared types and helpers for the serial word deserializer.
package deser_pkg;

   // Receive FSM: HUNT discards bits until a sync marker, RECV assembles words.
   typedef enum logic {
      HUNT = 1'b0,
      RECV = 1'b1
   } deser_state_e;

   // Width of a counter that can hold the values 0..width.
   function automatic int count_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/deser_out_stage.sv
// One-deep holding register between the deserializer and the parallel consumer.
//
// Handshake: a word transfers on any rising edge where out_valid and out_ready
// are both high. While out_valid is high and out_ready is low, out_data is held
// stable. A new word offered on load_valid is accepted when the buffer is empty
// or is being consumed on the same edge; otherwise it is dropped and 'drop'
// pulses high for that cycle so the caller can record an overrun.
module deser_out_stage #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             drop
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;

   // Next buffer contents: load when there is room, else clear on consume.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      drop    = load_valid & valid_q & ~out_ready;
      if (load_valid && !drop) begin
         data_d  = load_data;
         valid_d = 1'b1;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   // Buffer register, cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;

endmodule

// File: rtl/serial_word_deserializer.sv
// Collects WIDTH serial bits, optionally framed by a sync marker, into a word
// and hands each completed word to a one-deep valid/ready output buffer.
// Overrun and framing errors are kept as sticky flags until clr_err.
module serial_word_deserializer
   import deser_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MSB_FIRST = 0,
   parameter int SYNC_MODE = 1
) (
   input  logic                       clk,
   input  logic                       rstN,
   input  logic                       ser_valid,
   input  logic                       ser_data,
   input  logic                       ser_sync,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [count_w(WIDTH)-1:0]  bit_count,
   output logic                       busy,
   output logic                       overrun,
   output logic                       frame_err,
   input  logic                       clr_err
);

   localparam int CW = count_w(WIDTH);
   localparam deser_state_e RESET_STATE = (SYNC_MODE != 0) ? HUNT : RECV;

   deser_state_e     state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             overrun_q, overrun_d;
   logic             frame_err_q, frame_err_d;

   logic [WIDTH-1:0] shifted;
   logic             word_done;
   logic             set_frame_err;
   logic             drop;

   // Shift register contents after accepting ser_data; on the completing bit
   // this is also the finished word, so the buffer loads it on the same edge.
   always_comb begin
      if (MSB_FIRST != 0) begin
         shifted = {sr_q[WIDTH-2:0], ser_data};
      end else begin
         shifted = {ser_data, sr_q[WIDTH-1:1]};
      end
   end

   // Receive FSM: framing, bit counting and word completion.
   always_comb begin
      state_d       = state_q;
      sr_d          = sr_q;
      cnt_d         = cnt_q;
      word_done     = 1'b0;
      set_frame_err = 1'b0;
      case (state_q)
         HUNT: begin
            if (ser_valid && ser_sync) begin
               sr_d    = shifted;
               cnt_d   = CW'(1);
               state_d = RECV;
            end
         end
         RECV: begin
            if (ser_valid) begin
               // Old partial-word bits left in sr are pushed out by the next
               // WIDTH shifts, so a resync needs no explicit clear.
               sr_d = shifted;
               if (ser_sync) begin
                  set_frame_err = (cnt_q != '0);
                  cnt_d         = CW'(1);
               end else if (cnt_q == CW'(WIDTH - 1)) begin
                  word_done = 1'b1;
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: begin
            state_d = RESET_STATE;
         end
      endcase
   end

   // Sticky error flags; a set event on the same edge beats clr_err.
   always_comb begin
      overrun_d   = drop | (overrun_q & ~clr_err);
      frame_err_d = set_frame_err | (frame_err_q & ~clr_err);
   end

   // Receive state registers, cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q     <= RESET_STATE;
         sr_q        <= '0;
         cnt_q       <= '0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   deser_out_stage #(
      .WIDTH(WIDTH)
   ) u_out_stage (
      .clk       (clk),
      .rstN      (rstN),
      .load_valid(word_done),
      .load_data (shifted),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .drop      (drop)
   );

   assign bit_count = cnt_q;
   assign busy      = (state_q == RECV) && (cnt_q != '0);
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Bench for serial_word_deserializer: an LSB-first and an MSB-first instance
// share one serial stream and are checked against a bit-list reference model.
module tb_serial_word_deserializer;

   localparam int W  = 4;
   localparam int CW = 3;

   logic clk = 1'b0;
   logic rstN, ser_valid, ser_data, ser_sync, out_ready, clr_err;

   logic [W-1:0]  l_data, m_data;
   logic          l_valid, m_valid;
   logic [CW-1:0] l_cnt, m_cnt;
   logic          l_busy, m_busy, l_ovr, m_ovr, l_ferr, m_ferr;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: bits of the word in progress, in arrival order.
   bit         md_hunt;
   int         md_bits[$];
   bit         md_valid;
   logic [W-1:0] md_lsb, md_msb;
   bit         md_ovr, md_ferr;

   always #5 clk = ~clk;

   serial_word_deserializer #(.WIDTH(W), .MSB_FIRST(0), .SYNC_MODE(1)) dut_lsb (
      .clk(clk), .rstN(rstN), .ser_valid(ser_valid), .ser_data(ser_data),
      .ser_sync(ser_sync), .out_data(l_data), .out_valid(l_valid),
      .out_ready(out_ready), .bit_count(l_cnt), .busy(l_busy),
      .overrun(l_ovr), .frame_err(l_ferr), .clr_err(clr_err)
   );

   serial_word_deserializer #(.WIDTH(W), .MSB_FIRST(1), .SYNC_MODE(1)) dut_msb (
      .clk(clk), .rstN(rstN), .ser_valid(ser_valid), .ser_data(ser_data),
      .ser_sync(ser_sync), .out_data(m_data), .out_valid(m_valid),
      .out_ready(out_ready), .bit_count(m_cnt), .busy(m_busy),
      .overrun(m_ovr), .frame_err(m_ferr), .clr_err(clr_err)
   );

   function automatic void model_reset();
      md_hunt  = 1'b1;
      md_bits.delete();
      md_valid = 1'b0;
      md_lsb   = '0;
      md_msb   = '0;
      md_ovr   = 1'b0;
      md_ferr  = 1'b0;
   endfunction

   // One clock of the reference model, from the inputs seen at that edge.
   function automatic void model_update(bit v, bit d, bit s, bit rdy, bit clr);
      bit done = 1'b0;
      bit ferr_ev = 1'b0;
      bit drop;
      logic [W-1:0] wl = '0;
      logic [W-1:0] wm = '0;
      if (v) begin
         if (md_hunt) begin
            if (s) begin
               md_hunt = 1'b0;
               md_bits.delete();
               md_bits.push_back(int'(d));
            end
         end else if (s) begin
            ferr_ev = (md_bits.size() != 0);
            md_bits.delete();
            md_bits.push_back(int'(d));
         end else begin
            md_bits.push_back(int'(d));
            if (md_bits.size() == W) begin
               done = 1'b1;
               for (int i = 0; i < W; i++) begin
                  wl[i]       = md_bits[i][0];
                  wm[W-1-i]   = md_bits[i][0];
               end
               md_bits.delete();
            end
         end
      end
      drop = done && md_valid && !rdy;
      if (done && !drop) begin
         md_lsb   = wl;
         md_msb   = wm;
         md_valid = 1'b1;
      end else if (md_valid && rdy) begin
         md_valid = 1'b0;
      end
      md_ovr  = drop | (md_ovr & !clr);
      md_ferr = ferr_ev | (md_ferr & !clr);
   endfunction

   function automatic logic [21:0] exp_vec();
      logic [CW-1:0] c = CW'(md_bits.size());
      logic b = !md_hunt && (md_bits.size() != 0);
      return {md_valid, md_lsb, md_valid, md_msb,
              c, b, md_ovr, md_ferr, c, b, md_ovr, md_ferr};
   endfunction

   function automatic logic [21:0] obs_vec();
      return {l_valid, l_data, m_valid, m_data,
              l_cnt, l_busy, l_ovr, l_ferr, m_cnt, m_busy, m_ovr, m_ferr};
   endfunction

   // Drive one cycle of inputs, let the edge pass, advance the model.
   task automatic step(input bit v, input bit d, input bit s, input bit rdy,
                       input bit clr);
      ser_valid = v; ser_data = d; ser_sync = s; out_ready = rdy; clr_err = clr;
      @(posedge clk);
      #1;
      model_update(v, d, s, rdy, clr);
   endtask

   task automatic do_reset();
      ser_valid = 0; ser_data = 0; ser_sync = 0; out_ready = 0; clr_err = 0;
      rstN = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rstN = 1'b1;
   endtask

   task automatic test_reset();
      logic [21:0] o, e;
      do_reset();
      o = obs_vec(); e = exp_vec(); n_checks++;
      if (o !== e) $display("FAIL reset_values: got %h expected %h", o, e);
      else n_pass++;
      step(1, 1, 0, 1, 0);
      o = obs_vec(); e = exp_vec(); n_checks++;
      if (o !== e) $display("FAIL reset_hunt_no_sync: got %h expected %h", o, e);
      else n_pass++;
   endtask

   task automatic test_basic_word();
      logic [21:0] o, e;
      bit          bits[4]  = '{1, 0, 1, 1};
      int          cseq[4]  = '{1, 2, 3, 0};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1, bits[i], i == 0, 1, 0);
         o = obs_vec(); e = exp_vec(); n_checks++;
         if (o !== e) $display("FAIL basic_step%0d: got %h expected %h", i, o, e);
         else n_pass++;
         n_checks++;
         if (l_cnt !== CW'(cseq[i]))
            $display("FAIL basic_count%0d: got %0d expected %0d", i, l_cnt, cseq[i]);
         else n_pass++;
      end
      n_checks++;
      if ({l_valid, l_data, m_valid, m_data} !== {1'b1, 4'hD, 1'b1, 4'hB})
         $display("FAIL basic_word: got %b %h %b %h expected 1 d 1 b",
                  l_valid, l_data, m_valid, m_data);
      else n_pass++;
      step(0, 0, 0, 1, 0);
      o = obs_vec(); e = exp_vec(); n_checks++;
      if (o !== e) $display("FAIL basic_consume: got %h expected %h", o, e);
      else n_pass++;
   endtask

   task automatic test_hunt();
      logic [21:0] o, e;
      bit d[6] = '{1, 1, 0, 1, 0, 0};
      bit s[6] = '{0, 0, 1, 0, 0, 0};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1, d[i], s[i], 1, 0);
         o = obs_vec(); e = exp_vec(); n_checks++;
         if (o !== e) $display("FAIL hunt_step%0d: got %h expected %h", i, o, e);
         else n_pass++;
      end
      n_checks++;
      if ({l_valid, l_data, l_ferr} !== {1'b1, 4'h2, 1'b0})
         $display("FAIL hunt_word: got %b %h %b expected 1 2 0", l_valid, l_data, l_ferr);
      else n_pass++;
   endtask

   task automatic test_frame_err();
      logic [21:0] o, e;
      bit d[6] = '{1, 1, 0, 0, 0, 1};
      bit s[6] = '{1, 0, 1, 0, 0, 0};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1, d[i], s[i], 1, 0);
         o = obs_vec(); e = exp_vec(); n_checks++;
         if (o !== e) $display("FAIL ferr_step%0d: got %h expected %h", i, o, e);
         else n_pass++;
      end
      n_checks++;
      if ({l_ferr, l_data} !== {1'b1, 4'h8})
         $display("FAIL ferr_word: got %b %h expected 1 8", l_ferr, l_data);
      else n_pass++;
      step(0, 0, 0, 1, 1);
      n_checks++;
      if ({l_ferr, m_ferr} !== 2'b00)
         $display("FAIL ferr_clear: got %b%b expected 00", l_ferr, m_ferr);
      else n_pass++;
   endtask

   task automatic test_overrun();
      logic [21:0] o, e;
      bit d[8] = '{1, 1, 0, 0, 1, 0, 1, 0};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(1, d[i], (i % 4) == 0, 0, 0);
         o = obs_vec(); e = exp_vec(); n_checks++;
         if (o !== e) $display("FAIL ovr_step%0d: got %h expected %h", i, o, e);
         else n_pass++;
      end
      n_checks++;
      if ({l_valid, l_data, l_ovr} !== {1'b1, 4'h3, 1'b1})
         $display("FAIL ovr_hold: got %b %h %b expected 1 3 1", l_valid, l_data, l_ovr);
      else n_pass++;
      step(0, 0, 0, 1, 0);
      n_checks++;
      if ({l_valid, m_valid, l_ovr} !== 3'b001)
         $display("FAIL ovr_drain: got %b%b%b expected 001", l_valid, m_valid, l_ovr);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [21:0] o, e;
      bit d[8] = '{0, 1, 0, 1, 0, 1, 1, 0};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(1, d[i], (i % 4) == 0, i == 7, 0);
         o = obs_vec(); e = exp_vec(); n_checks++;
         if (o !== e) $display("FAIL b2b_step%0d: got %h expected %h", i, o, e);
         else n_pass++;
      end
      n_checks++;
      if ({l_valid, l_data, l_ovr} !== {1'b1, 4'h6, 1'b0})
         $display("FAIL b2b_word: got %b %h %b expected 1 6 0", l_valid, l_data, l_ovr);
      else n_pass++;
      step(1, 1, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      #2 rstN = 1'b0;
      #1;
      model_reset();
      o = obs_vec(); n_checks++;
      if (o !== 22'h0) $display("FAIL midword_reset: got %h expected 000000", o);
      else n_pass++;
      @(posedge clk);
      #1 rstN = 1'b1;
   endtask

   task automatic test_random();
      logic [21:0] o, e;
      bit v, d, s, r, c;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         v = ($urandom_range(0, 3) != 0);
         d = $urandom_range(0, 1);
         s = ($urandom_range(0, 5) == 0);
         r = $urandom_range(0, 1);
         c = ($urandom_range(0, 15) == 0);
         step(v, d, s, r, c);
         o = obs_vec(); e = exp_vec(); n_checks++;
         if (o !== e) $display("FAIL random_cycle%0d: got %h expected %h", i, o, e);
         else n_pass++;
      end
   endtask

   initial begin
      rstN = 1'b0;
      ser_valid = 0; ser_data = 0; ser_sync = 0; out_ready = 0; clr_err = 0;
      model_reset();
      test_reset();
      test_basic_word();
      test_hunt();
      test_frame_err();
      test_overrun();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no finish expected finish before 500000");
      $fatal(1, "bench timeout");
   end

endmodule
